// File: rtl/assoc_wb_cache.sv
// rtl/assoc_wb_cache.sv - N-way set-associative write-back, write-allocate data cache
// Miss handling walks TAG -> (WB) -> REFILL -> TAG; the post-refill lookup completes the access.
module assoc_wb_cache #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 8,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 8,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [31:0]              cpu_wdata,
    input  logic [3:0]               cpu_be,
    output logic [31:0]              cpu_rdata,
    output logic                     cpu_ready,
    output logic                     miss,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [32*LINE_WORDS-1:0] mem_wdata,
    input  logic [32*LINE_WORDS-1:0] mem_rdata,
    input  logic                     mem_ack,
    output logic [CNT_W-1:0]         hit_cnt,
    output logic [CNT_W-1:0]         miss_cnt
);
    localparam int INDEX_W = $clog2(SETS);
    localparam int AGE_W   = $clog2(WAYS);
    localparam int WORD_W  = $clog2(LINE_WORDS);
    localparam int OFF_W   = WORD_W + 2;
    localparam int TAG_W   = ADDR_W - OFF_W - INDEX_W;
    localparam int LINE_W  = 32 * LINE_WORDS;

    typedef enum logic [1:0] {IDLE, TAG, WB, REFILL} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic [AGE_W-1:0]    victim_q, victim_d;
    logic                relookup_q, relookup_d;
    logic [31:0]         cpu_rdata_q, cpu_rdata_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic                miss_q, miss_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     valid_d [SETS];
    logic [WAYS-1:0]     dirty_q [SETS];
    logic [WAYS-1:0]     dirty_d [SETS];
    logic [AGE_W-1:0]    age_q [SETS][WAYS];
    logic [AGE_W-1:0]    age_d [SETS][WAYS];
    logic [TAG_W-1:0]    tag_q [SETS][WAYS];
    logic [TAG_W-1:0]    tag_d [SETS][WAYS];
    logic [LINE_W-1:0]   data_q [SETS][WAYS];
    logic [LINE_W-1:0]   data_d [SETS][WAYS];

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic [WORD_W-1:0]   word;
    logic                hit, found_inv;
    logic [AGE_W-1:0]    hit_way, victim, age_hit;
    logic [LINE_W-1:0]   line;
    logic                unused_addr_bits;

    assign idx  = addr_q[OFF_W+INDEX_W-1:OFF_W];
    assign tag  = addr_q[ADDR_W-1:OFF_W+INDEX_W];
    assign word = addr_q[OFF_W-1:2];
    assign unused_addr_bits = ^addr_q[1:0];

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        victim    = '0;
        found_inv = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!found_inv && !valid_q[idx][w]) begin
                victim    = AGE_W'(w);
                found_inv = 1'b1;
            end
        end
        // With every way valid, the least recently used way carries the oldest age.
        if (!found_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx][w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        victim_d    = victim_q;
        relookup_d  = relookup_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        miss_d      = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        age_d       = age_q;
        tag_d       = tag_q;
        data_d      = data_q;
        line        = data_q[idx][hit_way];
        age_hit     = age_q[idx][hit_way];
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d     = cpu_addr;
                    we_d       = cpu_we;
                    wdata_d    = cpu_wdata;
                    be_d       = cpu_be;
                    relookup_d = 1'b0;
                    state_d    = TAG;
                end
            end
            TAG: begin
                if (hit) begin
                    if (we_q) begin
                        for (int b = 0; b < 4; b++) begin
                            if (be_q[b]) line[32*word + 8*b +: 8] = wdata_q[8*b +: 8];
                        end
                        data_d[idx][hit_way]  = line;
                        dirty_d[idx][hit_way] = 1'b1;
                    end else begin
                        cpu_rdata_d = line[32*word +: 32];
                    end
                    for (int w = 0; w < WAYS; w++) begin
                        if (age_q[idx][w] < age_hit) age_d[idx][w] = age_q[idx][w] + 1'b1;
                    end
                    age_d[idx][hit_way] = '0;
                    cpu_ready_d = 1'b1;
                    // The lookup that follows a refill belongs to an access already counted as a miss.
                    if (!relookup_q && hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt_q + 1'b1;
                    state_d = IDLE;
                end else begin
                    miss_d   = 1'b1;
                    victim_d = victim;
                    if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_d = miss_cnt_q + 1'b1;
                    mem_req_d = 1'b1;
                    if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[idx][victim], idx, {OFF_W{1'b0}}};
                        mem_wdata_d = data_q[idx][victim];
                        state_d     = WB;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = {tag, idx, {OFF_W{1'b0}}};
                        state_d    = REFILL;
                    end
                end
            end
            WB: begin
                if (mem_req_q && mem_ack) begin
                    dirty_d[idx][victim_q] = 1'b0;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = REFILL;
                end
            end
            REFILL: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {tag, idx, {OFF_W{1'b0}}};
                end else if (mem_ack) begin
                    data_d[idx][victim_q]  = mem_rdata;
                    tag_d[idx][victim_q]   = tag;
                    valid_d[idx][victim_q] = 1'b1;
                    dirty_d[idx][victim_q] = 1'b0;
                    mem_req_d  = 1'b0;
                    relookup_d = 1'b1;
                    state_d    = TAG;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            victim_q    <= '0;
            relookup_q  <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            miss_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            victim_q    <= victim_d;
            relookup_q  <= relookup_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            miss_q      <= miss_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            age_q       <= age_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign miss      = miss_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_assoc_wb_cache.sv
// tb/tb_assoc_wb_cache.sv - directed vector bench for assoc_wb_cache (2-way and 4-way instances)
module tb_assoc_wb_cache;
    logic         clk = 1'b0;
    logic         reset;
    logic         sel;
    logic         c_req, c_we;
    logic [31:0]  c_addr, c_wdata;
    logic [3:0]   c_be;
    logic         m_ack;
    logic [255:0] m_rdata;

    logic [31:0]  d0_rdata, d1_rdata, d0_maddr, d1_maddr;
    logic         d0_ready, d1_ready, d0_miss, d1_miss, d0_mreq, d1_mreq, d0_mwe, d1_mwe;
    logic [255:0] d0_mwdata, d1_mwdata;
    logic [15:0]  d0_hit, d0_mcnt;
    logic [1:0]   d1_hit, d1_mcnt;

    logic [31:0]  o_rdata, o_maddr;
    logic         o_ready, o_miss, o_mreq, o_mwe;
    logic [255:0] o_mwdata;
    logic [15:0]  o_hit, o_mcnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assoc_wb_cache #(.WAYS(2)) u_dut0 (
        .clk(clk), .reset(reset), .cpu_req(c_req & ~sel), .cpu_we(c_we), .cpu_addr(c_addr),
        .cpu_wdata(c_wdata), .cpu_be(c_be), .cpu_rdata(d0_rdata), .cpu_ready(d0_ready),
        .miss(d0_miss), .mem_req(d0_mreq), .mem_we(d0_mwe), .mem_addr(d0_maddr),
        .mem_wdata(d0_mwdata), .mem_rdata(m_rdata), .mem_ack(m_ack & ~sel),
        .hit_cnt(d0_hit), .miss_cnt(d0_mcnt)
    );

    assoc_wb_cache #(.WAYS(4), .CNT_W(2)) u_dut1 (
        .clk(clk), .reset(reset), .cpu_req(c_req & sel), .cpu_we(c_we), .cpu_addr(c_addr),
        .cpu_wdata(c_wdata), .cpu_be(c_be), .cpu_rdata(d1_rdata), .cpu_ready(d1_ready),
        .miss(d1_miss), .mem_req(d1_mreq), .mem_we(d1_mwe), .mem_addr(d1_maddr),
        .mem_wdata(d1_mwdata), .mem_rdata(m_rdata), .mem_ack(m_ack & sel),
        .hit_cnt(d1_hit), .miss_cnt(d1_mcnt)
    );

    assign o_rdata  = sel ? d1_rdata  : d0_rdata;
    assign o_ready  = sel ? d1_ready  : d0_ready;
    assign o_miss   = sel ? d1_miss   : d0_miss;
    assign o_mreq   = sel ? d1_mreq   : d0_mreq;
    assign o_mwe    = sel ? d1_mwe    : d0_mwe;
    assign o_maddr  = sel ? d1_maddr  : d0_maddr;
    assign o_mwdata = sel ? d1_mwdata : d0_mwdata;
    assign o_hit    = sel ? {14'b0, d1_hit}  : d0_hit;
    assign o_mcnt   = sel ? {14'b0, d1_mcnt} : d0_mcnt;

    // Backing memory: untouched lines read as word k = (line address << 4) + k.
    logic [255:0] mem_model [logic [31:0]];

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        if (mem_model.exists(a)) return mem_model[a];
        for (int k = 0; k < 8; k++) l[32*k +: 32] = (a << 4) + 32'(k);
        return l;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    int          r_lat, r_miss, r_wb, r_rf;
    logic        r_to, r_unstable;
    logic [31:0] r_rdata, r_wb_addr, r_wb_w2, r_rf_addr;

    // Called at a negedge; returns at the negedge where cpu_ready is seen.
    task automatic do_access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                             input logic [3:0] be, input int dly);
        int           held;
        logic         prev;
        logic [31:0]  s_addr;
        logic         s_we;
        logic [255:0] s_wd;
        r_lat = 0; r_miss = 0; r_wb = 0; r_rf = 0; r_to = 1'b1; r_unstable = 1'b0;
        r_rdata = '0; r_wb_addr = '0; r_wb_w2 = '0; r_rf_addr = '0;
        s_addr = '0; s_we = 1'b0; s_wd = '0; held = 0;
        c_req = 1'b1; c_addr = a; c_we = we; c_wdata = wd; c_be = be;
        @(negedge clk);
        c_req = 1'b0;
        prev  = 1'b0;
        for (int cyc = 1; cyc < 400; cyc++) begin
            m_ack = 1'b0;
            if (o_miss) r_miss++;
            if (o_mreq) begin
                if (!prev) begin
                    s_addr = o_maddr; s_we = o_mwe; s_wd = o_mwdata; held = 0;
                    if (s_we) begin
                        r_wb++; r_wb_addr = s_addr; r_wb_w2 = s_wd[95:64];
                    end else begin
                        r_rf++; r_rf_addr = s_addr;
                    end
                end else if (o_maddr !== s_addr || o_mwe !== s_we || o_mwdata !== s_wd) begin
                    r_unstable = 1'b1;
                end
                held++;
                if (held > dly) begin
                    m_ack = 1'b1;
                    if (s_we) mem_model[s_addr] = s_wd;
                    else m_rdata = line_of(s_addr);
                end
            end
            prev = o_mreq;
            if (o_ready) begin
                r_lat = cyc; r_rdata = o_rdata; r_to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        m_ack = 1'b0;
    endtask

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  be;
        int          dly;
        logic        exp_miss;
        int          exp_wb;
        logic [31:0] exp_wb_addr;
        logic [31:0] exp_wb_w2;
        logic [31:0] exp_rf_addr;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_hit_cnt;
        int          exp_miss_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic [31:0] a, input logic we,
                                input logic [31:0] wd, input logic [3:0] be, input int dly,
                                input logic em, input int ewb, input logic [31:0] ewa,
                                input logic [31:0] ew2, input logic [31:0] era,
                                input logic crd, input logic [31:0] erd, input int eh, input int emc);
        vec_t v;
        v.sel = s; v.addr = a; v.we = we; v.wd = wd; v.be = be; v.dly = dly;
        v.exp_miss = em; v.exp_wb = ewb; v.exp_wb_addr = ewa; v.exp_wb_w2 = ew2;
        v.exp_rf_addr = era; v.chk_rd = crd; v.exp_rd = erd;
        v.exp_hit_cnt = eh; v.exp_miss_cnt = emc;
        return v;
    endfunction

    initial begin
        //             sel addr   we  wdata         be    dly miss wb wb_addr wb_w2        rf_addr chk rdata        hit miss
        vecs.push_back(mk(0, 'h100, 0, 0,            0,    0, 1, 0, 0,     0,            'h100, 1, 'h1000,        0, 1));
        vecs.push_back(mk(0, 'h104, 0, 0,            0,    0, 0, 0, 0,     0,            0,     1, 'h1001,        1, 1));
        vecs.push_back(mk(0, 'h108, 1, 'hAABBCCDD,   'h3,  0, 0, 0, 0,     0,            0,     0, 0,             2, 1));
        vecs.push_back(mk(0, 'h108, 0, 0,            0,    0, 0, 0, 0,     0,            0,     1, 'h0000CCDD,    3, 1));
        vecs.push_back(mk(0, 'h200, 0, 0,            0,    0, 1, 0, 0,     0,            'h200, 1, 'h2000,        3, 2));
        vecs.push_back(mk(0, 'h104, 0, 0,            0,    0, 0, 0, 0,     0,            0,     1, 'h1001,        4, 2));
        vecs.push_back(mk(0, 'h300, 0, 0,            0,    0, 1, 0, 0,     0,            'h300, 1, 'h3000,        4, 3));
        vecs.push_back(mk(0, 'h400, 0, 0,            0,    5, 1, 1, 'h100, 'h0000CCDD,   'h400, 1, 'h4000,        4, 4));
        vecs.push_back(mk(0, 'h108, 0, 0,            0,    0, 1, 0, 0,     0,            'h100, 1, 'h0000CCDD,    4, 5));
        vecs.push_back(mk(0, 'h024, 1, 'h11223344,   'hF,  0, 1, 0, 0,     0,            'h020, 0, 0,             4, 6));
        vecs.push_back(mk(0, 'h024, 0, 0,            0,    0, 0, 0, 0,     0,            0,     1, 'h11223344,    5, 6));
        vecs.push_back(mk(0, 'h020, 0, 0,            0,    0, 0, 0, 0,     0,            0,     1, 'h0200,        6, 6));
        vecs.push_back(mk(1, 'h160, 0, 0,            0,    0, 1, 0, 0,     0,            'h160, 1, 'h1600,        0, 1));
        vecs.push_back(mk(1, 'h260, 0, 0,            0,    0, 1, 0, 0,     0,            'h260, 1, 'h2600,        0, 2));
        vecs.push_back(mk(1, 'h360, 0, 0,            0,    0, 1, 0, 0,     0,            'h360, 1, 'h3600,        0, 3));
        vecs.push_back(mk(1, 'h460, 0, 0,            0,    0, 1, 0, 0,     0,            'h460, 1, 'h4600,        0, 3));
        vecs.push_back(mk(1, 'h164, 0, 0,            0,    0, 0, 0, 0,     0,            0,     1, 'h1601,        1, 3));
        vecs.push_back(mk(1, 'h368, 0, 0,            0,    0, 0, 0, 0,     0,            0,     1, 'h3602,        2, 3));
        vecs.push_back(mk(1, 'h26C, 0, 0,            0,    0, 0, 0, 0,     0,            0,     1, 'h2603,        3, 3));
        vecs.push_back(mk(1, 'h560, 0, 0,            0,    0, 1, 0, 0,     0,            'h560, 1, 'h5600,        3, 3));
        vecs.push_back(mk(1, 'h160, 0, 0,            0,    0, 0, 0, 0,     0,            0,     1, 'h1600,        3, 3));
        vecs.push_back(mk(1, 'h260, 0, 0,            0,    0, 0, 0, 0,     0,            0,     1, 'h2600,        3, 3));
        vecs.push_back(mk(1, 'h360, 0, 0,            0,    0, 0, 0, 0,     0,            0,     1, 'h3600,        3, 3));
        vecs.push_back(mk(1, 'h460, 0, 0,            0,    0, 1, 0, 0,     0,            'h460, 1, 'h4600,        3, 3));

        reset = 1'b1; sel = 1'b0; c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0;
        m_ack = 1'b0; m_rdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", d0_ready, 0);
        chk("rst_miss", d0_miss, 0);
        chk("rst_mem_req", d0_mreq, 0);
        chk("rst_mem_we", d0_mwe, 0);
        chk("rst_rdata", d0_rdata, 0);
        chk("rst_mem_addr", d0_maddr, 0);
        chk("rst_mem_wdata_nz", d0_mwdata != '0, 0);
        chk("rst_hit_cnt", d0_hit, 0);
        chk("rst_miss_cnt", d0_mcnt, 0);
        chk("rst_dut1_miss_cnt", d1_mcnt, 0);

        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            do_access(vecs[i].addr, vecs[i].we, vecs[i].wd, vecs[i].be, vecs[i].dly);
            chk($sformatf("v%0d_timeout", i), r_to, 0);
            chk($sformatf("v%0d_miss_pulses", i), r_miss, vecs[i].exp_miss);
            chk($sformatf("v%0d_wb_count", i), r_wb, vecs[i].exp_wb);
            chk($sformatf("v%0d_refill_count", i), r_rf, vecs[i].exp_miss);
            chk($sformatf("v%0d_mem_stable", i), r_unstable, 0);
            if (vecs[i].exp_wb != 0) begin
                chk($sformatf("v%0d_wb_addr", i), r_wb_addr, vecs[i].exp_wb_addr);
                chk($sformatf("v%0d_wb_word2", i), r_wb_w2, vecs[i].exp_wb_w2);
            end
            if (vecs[i].exp_miss) chk($sformatf("v%0d_refill_addr", i), r_rf_addr, vecs[i].exp_rf_addr);
            else chk($sformatf("v%0d_hit_latency", i), r_lat, 2);
            if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), r_rdata, vecs[i].exp_rd);
            chk($sformatf("v%0d_hit_cnt", i), o_hit, vecs[i].exp_hit_cnt);
            chk($sformatf("v%0d_miss_cnt", i), o_mcnt, vecs[i].exp_miss_cnt);
        end

        // Stray ack while idle must not start or complete anything.
        sel = 1'b0;
        @(negedge clk);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stray_ack_mem_req_%0d", k), d0_mreq, 0);
            chk($sformatf("stray_ack_ready_%0d", k), d0_ready, 0);
            @(negedge clk);
        end
        chk("stray_ack_hit_cnt", d0_hit, 6);
        chk("stray_ack_miss_cnt", d0_mcnt, 6);
        do_access('h104, 0, 0, 0, 0);
        chk("post_stray_timeout", r_to, 0);
        chk("post_stray_miss", r_miss, 0);
        chk("post_stray_latency", r_lat, 2);
        chk("post_stray_rdata", r_rdata, 'h1001);
        chk("post_stray_hit_cnt", d0_hit, 7);

        // Reset while a refill is outstanding.
        c_req = 1'b1; c_addr = 'h0E0; c_we = 1'b0; c_be = '0; c_wdata = '0;
        @(negedge clk);
        c_req = 1'b0;
        r_to = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (d0_mreq) begin
                r_to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk("rst_mid_req_seen", r_to, 0);
        chk("rst_mid_req_addr", d0_maddr, 'h0E0);
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_req_async", d0_mreq, 0);
        chk("rst_mid_miss_cnt", d0_mcnt, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_access('h0E0, 0, 0, 0, 0);
        chk("after_rst_timeout", r_to, 0);
        chk("after_rst_miss", r_miss, 1);
        chk("after_rst_refill", r_rf, 1);
        chk("after_rst_refill_addr", r_rf_addr, 'h0E0);
        chk("after_rst_rdata", r_rdata, 'h0E00);
        chk("after_rst_miss_cnt", d0_mcnt, 1);
        chk("after_rst_hit_cnt", d0_hit, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
